// File: rtl/binary_multiplier_4_bit_pkg.sv
// binary_multiplier_4_bit_pkg: shared widths and FSM state encodings
package binary_multiplier_4_bit_pkg;
    localparam int DP_WIDTH  = 4;
    localparam int CNT_WIDTH = 3;
    typedef enum logic [1:0] {
        S_idle  = 2'b00,
        S_add   = 2'b01,
        S_shift = 2'b10
    } state_t;
endpackage

// File: rtl/binary_multiplier_4_bit_adder.sv
// Adder_4_bit_df: dataflow 4-bit ripple adder used as the multiplier datapath adder
module Adder_4_bit_df
    import binary_multiplier_4_bit_pkg::*;
(
    output logic [DP_WIDTH-1:0] Sum,
    output logic                C4,
    input  logic [DP_WIDTH-1:0] A,
    input  logic [DP_WIDTH-1:0] B,
    input  logic                C0
);
    assign {C4, Sum} = A + B + {{DP_WIDTH{1'b0}}, C0};
endmodule

// File: rtl/binary_multiplier_4_bit.sv
// binary_multiplier_4_bit: sequential 4x4 unsigned shift-and-add multiplier with Start/Ready handshake
module binary_multiplier_4_bit
    import binary_multiplier_4_bit_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  Start,
    input  logic [DP_WIDTH-1:0]   Multiplicand,
    input  logic [DP_WIDTH-1:0]   Multiplier,
    output logic [2*DP_WIDTH-1:0] Product,
    output logic                  Ready
);
    state_t               state_q, state_d;
    logic [DP_WIDTH-1:0]  a_q, a_d, q_q, q_d, b_q, b_d;
    logic                 c_q, c_d;
    logic [CNT_WIDTH-1:0] p_q, p_d;
    logic [DP_WIDTH-1:0]  sum;
    logic                 c4;

    Adder_4_bit_df u_adder (
        .Sum (sum),
        .C4  (c4),
        .A   (a_q),
        .B   (b_q),
        .C0  (1'b0)
    );

    assign Ready   = (state_q == S_idle);
    assign Product = {a_q, q_q};

    // Next-state and datapath updates: load on Start, add when Q[0] is set, then shift the {C,A,Q} chain
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        case (state_q)
            S_idle: begin
                if (Start) begin
                    b_d     = Multiplicand;
                    q_d     = Multiplier;
                    a_d     = '0;
                    c_d     = 1'b0;
                    p_d     = CNT_WIDTH'(DP_WIDTH);
                    state_d = S_add;
                end
            end
            S_add: begin
                p_d = p_q - 3'd1;
                if (q_q[0]) {c_d, a_d} = {c4, sum};
                state_d = S_shift;
            end
            S_shift: begin
                {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[DP_WIDTH-1:1]};
                state_d = (p_q == '0) ? S_idle : S_add;
            end
            default: state_d = S_idle;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears the result
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_idle;
            a_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
        end
    end
endmodule

// File: tb/tb_binary_multiplier_4_bit.sv
// tb_binary_multiplier_4_bit: scoreboard-driven bench for the 4x4 shift-and-add multiplier
module tb_binary_multiplier_4_bit;
    logic       clock = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset_b;
    logic       Start;
    logic [3:0] Multiplicand;
    logic [3:0] Multiplier;
    logic [7:0] Product;
    logic       Ready;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    binary_multiplier_4_bit dut (
        .clock        (clock),
        .reset_b      (reset_b),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready)
    );

    initial forever #5 if (clk_en) clock = ~clock;

    // Pulse Start for one cycle; returns at the negedge just after the accepting edge
    task automatic start_op(input logic [3:0] mc, input logic [3:0] mp);
        @(negedge clock);
        Multiplicand = mc;
        Multiplier   = mp;
        Start        = 1'b1;
        exp_q.push_back({4'b0, mc} * {4'b0, mp});
        @(negedge clock);
        Start = 1'b0;
    endtask

    // Counts edges until Ready is seen high, bounded so a stuck DUT cannot hang the run
    task automatic wait_ready(output int n);
        n = 0;
        while (Ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b1;
        Start = 1'b0;
        Multiplicand = 4'h0;
        Multiplier = 4'h0;
        #3 reset_b = 1'b0;
        #1;
        n_checks++;
        if (Product !== 8'h00) begin n_fail++; $display("FAIL reset_product got=%h exp=00", Product); end
        n_checks++;
        if (Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", Ready); end
        clk_en = 1'b1;
        repeat (2) @(negedge clock);
        reset_b = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] mcs[2] = '{4'hA, 4'h5};
        logic [3:0] mps[2] = '{4'h5, 4'hA};
        int n;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            start_op(mcs[i], mps[i]);
            n_checks++;
            if (Ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy[%0d] ready got=%b exp=0", i, Ready); end
            wait_ready(n);
            n_checks++;
            if (n != 8) begin n_fail++; $display("FAIL basic_latency[%0d] got=%0d exp=8", i, n); end
            e = exp_q.pop_front();
            n_checks++;
            if (Product !== e) begin n_fail++; $display("FAIL basic_product[%0d] got=%h exp=%h", i, Product, e); end
        end
    endtask

    task automatic test_corners();
        logic [3:0] mcs[3] = '{4'hF, 4'h0, 4'h1};
        logic [3:0] mps[3] = '{4'hF, 4'hB, 4'h9};
        logic [7:0] ref_p[3] = '{8'hE1, 8'h00, 8'h09};
        int n;
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            start_op(mcs[i], mps[i]);
            wait_ready(n);
            n_checks++;
            if (n != 8) begin n_fail++; $display("FAIL corner_latency[%0d] got=%0d exp=8", i, n); end
            e = exp_q.pop_front();
            n_checks++;
            if (Product !== e || e !== ref_p[i]) begin n_fail++; $display("FAIL corner_product[%0d] got=%h exp=%h", i, Product, ref_p[i]); end
        end
    endtask

    task automatic test_busy_start();
        int n = 0;
        logic [7:0] e;
        start_op(4'hA, 4'h5);
        while (Ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 3 || n == 6) begin
                Start = 1'b1;
                Multiplicand = 4'h3;
                Multiplier = 4'h3;
            end else Start = 1'b0;
        end
        Start = 1'b0;
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL busy_latency got=%0d exp=8", n); end
        e = exp_q.pop_front();
        n_checks++;
        if (Product !== e) begin n_fail++; $display("FAIL busy_product got=%h exp=%h", Product, e); end
        repeat (2) @(negedge clock);
        n_checks++;
        if (Ready !== 1'b1 || Product !== e) begin n_fail++; $display("FAIL busy_hold ready=%b product=%h exp ready=1 product=%h", Ready, Product, e); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] e;
        @(negedge clock);
        Multiplicand = 4'h7;
        Multiplier = 4'h6;
        Start = 1'b1;
        exp_q.push_back(8'd42);
        exp_q.push_back(8'd42);
        @(negedge clock);
        wait_ready(n);
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL b2b_latency0 got=%0d exp=8", n); end
        e = exp_q.pop_front();
        n_checks++;
        if (Product !== e) begin n_fail++; $display("FAIL b2b_product0 got=%h exp=%h", Product, e); end
        @(negedge clock);
        n_checks++;
        if (Ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_pulse got=%b exp=0", Ready); end
        wait_ready(n);
        Start = 1'b0;
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL b2b_latency1 got=%0d exp=8", n); end
        e = exp_q.pop_front();
        n_checks++;
        if (Product !== e) begin n_fail++; $display("FAIL b2b_product1 got=%h exp=%h", Product, e); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] e;
        start_op(4'hF, 4'hF);
        repeat (2) @(negedge clock);
        #2 reset_b = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (Ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b exp=1", Ready); end
        n_checks++;
        if (Product !== 8'h00) begin n_fail++; $display("FAIL midreset_product got=%h exp=00", Product); end
        @(negedge clock);
        reset_b = 1'b1;
        start_op(4'h2, 4'h3);
        wait_ready(n);
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL midreset_latency got=%0d exp=8", n); end
        e = exp_q.pop_front();
        n_checks++;
        if (Product !== e || e !== 8'h06) begin n_fail++; $display("FAIL midreset_product2 got=%h exp=06", Product); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
